calc_port_responder: RTL and testbench

CALC_PORT_RESPONDER -- requirements
Module: calc_port_responder

---
 rtl/calc_pkg.sv | 32 +++
 rtl/calc_alu.sv | 63 ++++++
 rtl/calc_port_responder.sv | 125 ++++++++++++
 tb/tb_calc_port_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : calc_pkg
//  Purpose  : Command/response code constants and FSM state encoding shared
//             by the calculator port responder and its ALU.
//  Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Command codes (bit 0 is the MSB)
    localparam logic [0:3] c_CMD_NOP = 4'd0;
    localparam logic [0:3] c_CMD_ADD = 4'd1;
    localparam logic [0:3] c_CMD_SUB = 4'd2;
    localparam logic [0:3] c_CMD_SHL = 4'd5;
    localparam logic [0:3] c_CMD_SHR = 4'd6;

    // Response codes
    localparam logic [0:1] c_RESP_NONE = 2'd0;
    localparam logic [0:1] c_RESP_OK   = 2'd1;
    localparam logic [0:1] c_RESP_OVF  = 2'd2;
    localparam logic [0:1] c_RESP_INV  = 2'd3;

    // Request-handling FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP2  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_alu.sv
`default_nettype none
// ============================================================================
//  Module   : calc_alu
//  Purpose  : Purely combinational arithmetic for the port responder:
//             add / subtract with overflow detection and logical shifts.
//             Any code not recognised yields the invalid-command response.
//  Revision : 1.0 - initial release
// ============================================================================
module calc_alu
    import calc_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [0:3]    cmd,
    input  logic [0:DW-1] op1,
    input  logic [0:DW-1] op2,
    output logic [0:1]    resp,
    output logic [0:DW-1] result
);

    logic [0:DW] w_sum;     // bit 0 is the carry-out
    logic [4:0]  w_shamt;   // low five bits of operand 2

    // Decode the command and form response code plus result data
    always_comb begin
        w_sum   = {1'b0, op1} + {1'b0, op2};
        w_shamt = op2[DW-5:DW-1];
        resp    = c_RESP_INV;
        result  = '0;
        case (cmd)
            c_CMD_ADD: begin
                if (w_sum[0]) begin
                    resp = c_RESP_OVF;
                end else begin
                    resp   = c_RESP_OK;
                    result = w_sum[1:DW];
                end
            end
            c_CMD_SUB: begin
                if (op2 > op1) begin
                    resp = c_RESP_OVF;
                end else begin
                    resp   = c_RESP_OK;
                    result = op1 - op2;
                end
            end
            c_CMD_SHL: begin
                resp   = c_RESP_OK;
                result = op1 << w_shamt;
            end
            c_CMD_SHR: begin
                resp   = c_RESP_OK;
                result = op1 >> w_shamt;
            end
            default: begin
                resp   = c_RESP_INV;
                result = '0;
            end
        endcase
    end

endmodule : calc_alu
`default_nettype wire

// File: rtl/calc_port_responder.sv
`default_nettype none
// ============================================================================
//  Module   : calc_port_responder
//  Purpose  : Two-cycle request port (command + operand 1, then operand 2)
//             followed by a programmable latency and a single-cycle
//             registered response. Commands arriving while busy are dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module calc_port_responder
    import calc_pkg::*;
#(
    parameter int LATENCY = 3,   // 1..8
    parameter int DW      = 32
) (
    input  logic          c_clk,
    input  logic          reset,        // asynchronous, active low
    input  logic [0:3]    req_cmd_in,
    input  logic [0:DW-1] req_data_in,
    output logic [0:1]    out_resp,
    output logic [0:DW-1] out_data,
    output logic          busy
);

    // WAIT holds for LATENCY cycles: the counter is loaded with LATENCY-1
    // and the response is launched on the edge where it reads zero.
    localparam logic [2:0] c_CNT_LOAD = 3'(LATENCY - 1);

    state_e        r_state_q, w_state_d;
    logic [2:0]    r_cnt_q,   w_cnt_d;
    logic [0:3]    r_cmd_q,   w_cmd_d;
    logic [0:DW-1] r_op1_q,   w_op1_d;
    logic [0:DW-1] r_op2_q,   w_op2_d;
    logic [0:1]    r_resp_q,  w_resp_d;
    logic [0:DW-1] r_data_q,  w_data_d;
    logic          r_busy_q,  w_busy_d;

    logic          w_accept;
    logic [0:1]    w_alu_resp;
    logic [0:DW-1] w_alu_result;

    calc_alu #(
        .DW     (DW)
    ) u_alu (
        .cmd    (r_cmd_q),
        .op1    (r_op1_q),
        .op2    (r_op2_q),
        .resp   (w_alu_resp),
        .result (w_alu_result)
    );

    // A request may start from IDLE or on the edge that ends the RESP cycle
    assign w_accept = ((r_state_q == IDLE) || (r_state_q == RESP)) &&
                      (req_cmd_in != c_CMD_NOP);

    // Next-state, operand capture and response launch
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_cmd_d   = r_cmd_q;
        w_op1_d   = r_op1_q;
        w_op2_d   = r_op2_q;
        w_resp_d  = c_RESP_NONE;
        w_data_d  = '0;
        case (r_state_q)
            IDLE: begin
                w_state_d = IDLE;
            end
            OP2: begin
                w_op2_d   = req_data_in;
                w_cnt_d   = c_CNT_LOAD;
                w_state_d = WAIT;
            end
            WAIT: begin
                if (r_cnt_q == 3'd0) begin
                    w_state_d = RESP;
                    w_resp_d  = w_alu_resp;
                    w_data_d  = w_alu_result;
                end else begin
                    w_cnt_d = r_cnt_q - 3'd1;
                end
            end
            RESP: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
        if (w_accept) begin
            w_cmd_d   = req_cmd_in;
            w_op1_d   = req_data_in;
            w_state_d = OP2;
        end
        w_busy_d = (w_state_d != IDLE);
    end

    // State and registered outputs; reset drops any request in flight
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= IDLE;
            r_cnt_q   <= 3'd0;
            r_cmd_q   <= c_CMD_NOP;
            r_op1_q   <= '0;
            r_op2_q   <= '0;
            r_resp_q  <= c_RESP_NONE;
            r_data_q  <= '0;
            r_busy_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_cmd_q   <= w_cmd_d;
            r_op1_q   <= w_op1_d;
            r_op2_q   <= w_op2_d;
            r_resp_q  <= w_resp_d;
            r_data_q  <= w_data_d;
            r_busy_q  <= w_busy_d;
        end
    end

    assign out_resp = r_resp_q;
    assign out_data = r_data_q;
    assign busy     = r_busy_q;

endmodule : calc_port_responder
`default_nettype wire

// File: tb/tb_calc_port_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_port_responder
//  Purpose  : Self-checking bench: table of operand/result vectors plus
//             sequences for back-to-back issue, busy drop and reset abort.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_calc_port_responder;

    localparam int LAT = 3;
    localparam int DW  = 32;

    logic          c_clk = 1'b0;
    logic          reset = 1'b0;
    logic [0:3]    req_cmd_in = 4'd0;
    logic [0:DW-1] req_data_in = '0;
    logic [0:1]    out_resp;
    logic [0:DW-1] out_data;
    logic          busy;

    calc_port_responder #(
        .LATENCY     (LAT),
        .DW          (DW)
    ) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .busy        (busy)
    );

    always #5 c_clk = ~c_clk;

    int cyc = 0;
    always @(posedge c_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [0:1]    resp;
        logic [0:DW-1] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    typedef struct {
        logic [0:3]    cmd;
        logic [0:DW-1] op1;
        logic [0:DW-1] op2;
        logic [0:1]    resp;
        logic [0:DW-1] data;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Response monitor / scoreboard
    always @(negedge c_clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_resp: got none by cycle %0d, required at cycle %0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (out_resp != 2'd0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got resp %0d data 0x%0h, required none (cycle %0d)",
                         out_resp, out_data, cyc);
            end else begin
                e = sb.pop_front();
                check("resp_code", 64'(out_resp), 64'(e.resp));
                check("resp_data", 64'(out_data), 64'(e.data));
                check("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else begin
            check("idle_data", 64'(out_data), 64'd0);
        end
    end

    // Command cycle then operand-2 cycle; expectation pushed at issue
    task automatic send(input logic [0:3] cmd, input logic [0:DW-1] op1,
                        input logic [0:DW-1] op2, input logic [0:1] er,
                        input logic [0:DW-1] ed);
        @(posedge c_clk); #1;
        req_cmd_in  = cmd;
        req_data_in = op1;
        sb.push_back('{er, ed, cyc + LAT + 2});
        @(posedge c_clk); #1;
        req_cmd_in  = 4'd0;
        req_data_in = op2;
        @(posedge c_clk); #1;
        req_data_in = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'd1,  32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000};
        tbl[1]  = '{4'd1,  32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0};
        tbl[2]  = '{4'd2,  32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0};
        tbl[3]  = '{4'd3,  32'h0000_0001, 32'h0000_0000, 2'd3, 32'h0};
        tbl[4]  = '{4'd4,  32'h0000_0001, 32'h0000_0000, 2'd3, 32'h0};
        tbl[5]  = '{4'd5,  32'h0000_0001, 32'h0000_0024, 2'd1, 32'h0000_0010};
        tbl[6]  = '{4'd6,  32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001};
        tbl[7]  = '{4'd1,  32'hFFFF_FFFE, 32'h0000_0001, 2'd1, 32'hFFFF_FFFF};
        tbl[8]  = '{4'd2,  32'h0000_1234, 32'h0000_1234, 2'd1, 32'h0};
        tbl[9]  = '{4'd2,  32'h0000_0064, 32'h0000_0001, 2'd1, 32'h0000_0063};
        tbl[10] = '{4'd5,  32'h0000_0003, 32'hFFFF_FFE1, 2'd1, 32'h0000_0006};
        tbl[11] = '{4'd6,  32'h0000_00F0, 32'h0000_0000, 2'd1, 32'h0000_00F0};
        tbl[12] = '{4'd15, 32'h0000_0005, 32'h0000_0005, 2'd3, 32'h0};
        tbl[13] = '{4'd7,  32'h0000_0001, 32'h0000_0000, 2'd3, 32'h0};

        // Reset state
        repeat (2) @(posedge c_clk);
        #1;
        check("rst_resp", 64'(out_resp), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;

        // Table-driven vectors, one request at a time
        for (int i = 0; i < 14; i++) begin
            check("busy_idle", 64'(busy), 64'd0);
            send(tbl[i].cmd, tbl[i].op1, tbl[i].op2, tbl[i].resp, tbl[i].data);
            repeat (LAT + 1) @(posedge c_clk);
            #1;
        end

        // Back-to-back: second command presented during the RESP cycle
        send(4'd1, 32'd1, 32'd2, 2'd1, 32'd3);
        repeat (LAT - 1) @(posedge c_clk);
        send(4'd2, 32'd9, 32'd4, 2'd1, 32'd5);
        repeat (LAT + 1) @(posedge c_clk);
        #1;
        check("b2b_busy_end", 64'(busy), 64'd0);

        // Command while busy is dropped; busy stays high to RESP
        send(4'd1, 32'h10, 32'h20, 2'd1, 32'h30);
        req_cmd_in  = 4'd1;
        req_data_in = 32'h55;
        @(posedge c_clk); #1;
        req_cmd_in  = 4'd0;
        req_data_in = '0;
        check("drop_busy", 64'(busy), 64'd1);
        for (int i = 0; i < LAT - 1; i++) begin
            @(posedge c_clk); #1;
            check("drop_busy", 64'(busy), 64'd1);
        end
        @(posedge c_clk); #1;
        check("drop_busy_end", 64'(busy), 64'd0);
        repeat (LAT + 2) @(posedge c_clk);
        #1;

        // Reset during WAIT drops the request
        send(4'd1, 32'd7, 32'd8, 2'd1, 32'd15);
        @(posedge c_clk); #1;
        reset = 1'b0;
        sb.delete();
        #1;
        check("arst_resp", 64'(out_resp), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge c_clk);
        #1;
        reset       = 1'b1;
        req_cmd_in  = 4'd1;
        req_data_in = 32'd2;
        sb.push_back('{2'd1, 32'd5, cyc + LAT + 2});
        @(posedge c_clk); #1;
        check("first_accept_busy", 64'(busy), 64'd1);
        req_cmd_in  = 4'd0;
        req_data_in = 32'd3;
        @(posedge c_clk); #1;
        req_data_in = '0;
        repeat (LAT + 1) @(posedge c_clk);
        #1;
        check("post_rst_busy", 64'(busy), 64'd0);

        // Drain with a bounded wait
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge c_clk);
        n_cmp++;
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, required 0", sb.size());
        end
        repeat (2) @(negedge c_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_calc_port_responder
`default_nettype wire
